// File: rtl/adder_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// The operands are cut into NSEG segments of SEG_W bits; stage k adds segment k
// with a flattened lookahead carry network and hands its carry to stage k+1.
// All stages advance together (lockstep); a full output with no taker stalls them all.
module adder_cla_pipe #(
  parameter int WIDTH = 64,
  parameter int SEG_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c_in,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c_out,
  output logic             o_ovf
);

  localparam int NSEG = WIDTH / SEG_W;

  // Catch parameter sets that cannot be split into whole segments.
  if ((SEG_W < 1) || (WIDTH < SEG_W) || ((WIDTH % SEG_W) != 0)) begin : g_param_check
    $error("adder_cla_pipe: WIDTH must be a positive multiple of SEG_W");
  end

  // One segment of lookahead addition.
  // Returns {carry into segment MSB, carry out, sum}. Every carry is written as a
  // sum of generate terms gated by the propagate chain below it, so no carry
  // depends on another carry inside the segment.
  function automatic logic [SEG_W+1:0] cla_seg(
    input logic [SEG_W-1:0] a,
    input logic [SEG_W-1:0] b,
    input logic             cin
  );
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c;
    logic             pp;
    g    = a & b;
    p    = a ^ b;
    c    = {(SEG_W+1){1'b0}};
    c[0] = cin;
    for (int i = 0; i < SEG_W; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    return {c[SEG_W-1], c[SEG_W], p ^ c[SEG_W-1:0]};
  endfunction

  // Per-stage state: valid, carry out of the segment just added, overflow of
  // that segment's MSB, operand copies still to be consumed, partial result.
  logic             valid_r [NSEG];
  logic             carry_r [NSEG];
  logic             ovf_r   [NSEG];
  logic [WIDTH-1:0] a_r     [NSEG];
  logic [WIDTH-1:0] b_r     [NSEG];
  logic [WIDTH-1:0] s_r     [NSEG];

  logic             valid_s [NSEG];
  logic             carry_s [NSEG];
  logic             ovf_s   [NSEG];
  logic [WIDTH-1:0] a_s     [NSEG];
  logic [WIDTH-1:0] b_s     [NSEG];
  logic [WIDTH-1:0] s_s     [NSEG];
  logic [SEG_W+1:0] res_s   [NSEG];

  logic [WIDTH-1:0] b0_s;
  logic             c0_s;
  logic             adv_s;

  // Global advance and the next value of every stage.
  always_comb begin
    adv_s = !valid_r[NSEG-1] || i_ready;
    b0_s  = i_sub ? ~i_b : i_b;
    c0_s  = i_sub ? 1'b1 : i_c_in;
    for (int k = 0; k < NSEG; k++) begin
      valid_s[k] = 1'b0;
      carry_s[k] = 1'b0;
      ovf_s[k]   = 1'b0;
      a_s[k]     = {WIDTH{1'b0}};
      b_s[k]     = {WIDTH{1'b0}};
      s_s[k]     = {WIDTH{1'b0}};
      res_s[k]   = {(SEG_W+2){1'b0}};
    end

    // Stage 0 takes the (possibly inverted) operands straight from the ports.
    res_s[0]            = cla_seg(i_a[SEG_W-1:0], b0_s[SEG_W-1:0], c0_s);
    valid_s[0]          = i_valid;
    a_s[0]              = i_a;
    b_s[0]              = b0_s;
    s_s[0][SEG_W-1:0]   = res_s[0][SEG_W-1:0];
    carry_s[0]          = res_s[0][SEG_W];
    ovf_s[0]            = res_s[0][SEG_W+1] ^ res_s[0][SEG_W];

    // Later stages add their own segment using the previous stage's carry.
    for (int k = 1; k < NSEG; k++) begin
      res_s[k]   = cla_seg(a_r[k-1][k*SEG_W +: SEG_W], b_r[k-1][k*SEG_W +: SEG_W], carry_r[k-1]);
      valid_s[k] = valid_r[k-1];
      a_s[k]     = a_r[k-1];
      b_s[k]     = b_r[k-1];
      s_s[k]     = s_r[k-1];
      s_s[k][k*SEG_W +: SEG_W] = res_s[k][SEG_W-1:0];
      carry_s[k] = res_s[k][SEG_W];
      ovf_s[k]   = res_s[k][SEG_W+1] ^ res_s[k][SEG_W];
    end
  end

  // Stage registers: cleared by reset, shifted in lockstep when the pipe advances.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        valid_r[k] <= 1'b0;
        carry_r[k] <= 1'b0;
        ovf_r[k]   <= 1'b0;
        a_r[k]     <= {WIDTH{1'b0}};
        b_r[k]     <= {WIDTH{1'b0}};
        s_r[k]     <= {WIDTH{1'b0}};
      end
    end else if (adv_s) begin
      for (int k = 0; k < NSEG; k++) begin
        valid_r[k] <= valid_s[k];
        carry_r[k] <= carry_s[k];
        ovf_r[k]   <= ovf_s[k];
        a_r[k]     <= a_s[k];
        b_r[k]     <= b_s[k];
        s_r[k]     <= s_s[k];
      end
    end
  end

  assign o_ready = adv_s;
  assign o_valid = valid_r[NSEG-1];
  assign o_s     = s_r[NSEG-1];
  assign o_c_out = carry_r[NSEG-1];
  assign o_ovf   = ovf_r[NSEG-1];

endmodule

// File: tb/tb_adder_cla_pipe.sv
// Bench for adder_cla_pipe: three instances (64/16, 32/32, 24/8) checked
// against an arithmetic reference model through per-instance expectation queues.
module tb_adder_cla_pipe;

  logic        clk;
  logic        rst_n;
  logic        vin    [3];
  logic        rdy_in [3];
  logic        cin_in [3];
  logic        sub_in [3];
  logic [63:0] a_in   [3];
  logic [63:0] b_in   [3];

  logic [2:0]  ordy;
  logic [2:0]  ovld;
  logic [2:0]  oc;
  logic [2:0]  oovf;
  logic [63:0] s0;
  logic [31:0] s1;
  logic [23:0] s2;

  logic [65:0] q0[$];
  logic [65:0] q1[$];
  logic [65:0] q2[$];

  int n_chk;
  int n_pass;
  int nout [3];
  int cyc;
  bit rand_bp;

  adder_cla_pipe #(.WIDTH(64), .SEG_W(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[0]), .o_ready(ordy[0]),
    .i_a(a_in[0]), .i_b(b_in[0]), .i_c_in(cin_in[0]), .i_sub(sub_in[0]),
    .o_valid(ovld[0]), .i_ready(rdy_in[0]), .o_s(s0), .o_c_out(oc[0]), .o_ovf(oovf[0]));

  adder_cla_pipe #(.WIDTH(32), .SEG_W(32)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[1]), .o_ready(ordy[1]),
    .i_a(a_in[1][31:0]), .i_b(b_in[1][31:0]), .i_c_in(cin_in[1]), .i_sub(sub_in[1]),
    .o_valid(ovld[1]), .i_ready(rdy_in[1]), .o_s(s1), .o_c_out(oc[1]), .o_ovf(oovf[1]));

  adder_cla_pipe #(.WIDTH(24), .SEG_W(8)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[2]), .o_ready(ordy[2]),
    .i_a(a_in[2][23:0]), .i_b(b_in[2][23:0]), .i_c_in(cin_in[2]), .i_sub(sub_in[2]),
    .o_valid(ovld[2]), .i_ready(rdy_in[2]), .o_s(s2), .o_c_out(oc[2]), .o_ovf(oovf[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int width_of(int d);
    return (d == 0) ? 64 : ((d == 1) ? 32 : 24);
  endfunction

  function automatic logic [63:0] get_s(int d);
    return (d == 0) ? s0 : ((d == 1) ? {32'd0, s1} : {40'd0, s2});
  endfunction

  // Reference: plain integer addition, overflow by the sign rule
  // (operands of equal sign giving a result of the other sign).
  function automatic logic [65:0] model(int w, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
    logic [63:0] m;
    logic [63:0] am;
    logic [63:0] bm;
    logic [63:0] s;
    logic [65:0] full;
    logic        co;
    logic        ov;
    m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & m;
    bm   = (sub ? ~b : b) & m;
    full = {2'b00, am} + {2'b00, bm} + {65'd0, (sub ? 1'b1 : cin)};
    s    = full[63:0] & m;
    co   = full[w];
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Output monitor: every output transfer must match the oldest expectation.
  always begin
    logic [65:0] e;
    logic        have;
    @(negedge clk);
    #2;
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (ovld[d] && rdy_in[d]) begin
          have = 1'b0;
          e    = 66'd0;
          case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
          endcase
          if (have) check($sformatf("result_d%0d", d), {oovf[d], oc[d], get_s(d)}, e);
          else      check($sformatf("unexpected_out_d%0d", d), {65'd0, ovld[d]}, 66'd0);
          nout[d]++;
        end
      end
    end
  end

  // Random backpressure on the 24-bit instance when enabled.
  always @(negedge clk) begin
    if (rand_bp) rdy_in[2] = ($urandom_range(0, 2) != 0);
  end

  task automatic send(input int d, input logic [63:0] a, input logic [63:0] b,
                      input logic cin, input logic sub);
    int n;
    vin[d] = 1'b1; a_in[d] = a; b_in[d] = b; cin_in[d] = cin; sub_in[d] = sub;
    #1;
    n = 0;
    while (!ordy[d] && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ordy[d]) begin
      check($sformatf("ready_timeout_d%0d", d), {65'd0, ordy[d]}, 66'd1);
    end else begin
      case (d)
        0: q0.push_back(model(64, a, b, cin, sub));
        1: q1.push_back(model(32, a, b, cin, sub));
        default: q2.push_back(model(24, a, b, cin, sub));
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle(input int d);
    vin[d] = 1'b0;
  endtask

  // Measures negedges from the accepting edge until o_valid appears.
  task automatic latency(input int d, input int exp);
    int n;
    n = 1;
    while (!ovld[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("latency_d%0d", d), 66'(n), 66'(exp));
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 4) == 0) v = {64{1'b1}};
    if ($urandom_range(0, 6) == 0) v = 64'h8000_0000_0000_0000;
    return v;
  endfunction

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [63:0] held;
    int          c0;
    int          o0;
    n_chk = 0; n_pass = 0; cyc = 0; rand_bp = 1'b0;
    for (int d = 0; d < 3; d++) begin
      vin[d] = 1'b0; rdy_in[d] = 1'b1; cin_in[d] = 1'b0; sub_in[d] = 1'b0;
      a_in[d] = 64'd0; b_in[d] = 64'd0; nout[d] = 0;
    end
    rst_n = 1'b0;
    drain(3);

    // Reset state.
    check("rst_valid", {63'd0, ovld}, 66'd0);
    check("rst_cout_ovf", {60'd0, oc, oovf}, 66'd0);
    check("rst_s0", {2'b00, s0}, 66'd0);
    check("rst_s12", {10'd0, s1, s2}, 66'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {63'd0, ordy}, 66'd7);

    // Full ripple across all segments, then the two subtract cases.
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    idle(0);
    latency(0, 4);
    check("ripple_direct", {oovf[0], oc[0], s0}, {1'b0, 1'b1, 64'd0});
    drain(2);
    send(0, 64'd5, 64'd7, 1'b1, 1'b1);
    send(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    idle(0);
    drain(6);

    // 100 back-to-back random ops: one accept per cycle.
    c0 = cyc;
    o0 = nout[0];
    for (int i = 0; i < 100; i++) begin
      send(0, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check("throughput", 66'(cyc - c0), 66'd100);
    idle(0);
    drain(8);
    check("b2b_count", 66'(nout[0] - o0), 66'd100);

    // Backpressure with a full pipeline.
    o0 = nout[0];
    rdy_in[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(0, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(0);
    held = s0;
    check("stall_valid", {65'd0, ovld[0]}, 66'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("stall_ready", {65'd0, ordy[0]}, 66'd0);
      check("stall_hold", {2'b00, s0}, {2'b00, held});
    end
    rdy_in[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(0, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(0);
    drain(8);
    check("bp_count", 66'(nout[0] - o0), 66'd7);

    // Reset with three ops in flight; the oldest is already at the output.
    for (int i = 0; i < 3; i++) send(0, rnd64(), rnd64(), 1'b0, 1'b0);
    idle(0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {65'd0, ovld[0]}, 66'd0);
    q0.delete();
    o0 = nout[0];
    drain(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("no_stale", {65'd0, ovld[0]}, 66'd0);
    end
    check("rst_no_out", 66'(nout[0] - o0), 66'd0);

    // Narrow instances: latency, then random streams.
    send(1, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0);
    idle(1);
    latency(1, 1);
    send(2, 64'hFF_FFFF, 64'd1, 1'b0, 1'b0);
    idle(2);
    latency(2, 3);
    drain(4);
    for (int i = 0; i < 60; i++) begin
      send(1, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(1);
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(2, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        idle(2);
        @(negedge clk);
      end
    end
    idle(2);
    rand_bp = 1'b0;
    @(negedge clk);
    rdy_in[2] = 1'b1;
    drain(10);
    check("q_empty", 66'(q0.size() + q1.size() + q2.size()), 66'd0);
    check("narrow_count", 66'(nout[1] + nout[2]), 66'd122);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
